// File: rtl/ccff_chain_loader.sv
// rtl/ccff_chain_loader.sv - configuration-chain loader with tail readback
//
// Purpose: takes configuration words from the bitstream host, shifts them
// LSB-first into a DFF configuration chain and captures the bits falling out
// of the chain tail as readback words (the previous load's contents).
//
// Ports:
//   prog_clk    in   configuration clock, shared with the chain DFFs
//   prog_reset  in   synchronous active-high reset
//   start       in   request to begin a load (honoured in IDLE or DONE only)
//   cfg_data    in   configuration word, bit 0 shifted first
//   cfg_valid   in   cfg_data valid
//   cfg_ready   out  loader accepts a word this cycle
//   ccff_head   out  serial data into the chain head
//   shift_en    out  chain clock enable
//   ccff_tail   in   serial data from the chain tail
//   rb_data     out  readback word of captured tail bits
//   rb_valid    out  one-cycle pulse, rb_data valid
//   busy        out  load in progress
//   done        out  last load completed (level)
module ccff_chain_loader #(
  parameter int WORD_W    = 32,
  parameter int CHAIN_LEN = 1024,
  parameter int CNT_W     = $clog2(CHAIN_LEN + 1)
) (
  input  logic              prog_clk,
  input  logic              prog_reset,
  input  logic              start,
  input  logic [WORD_W-1:0] cfg_data,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  output logic              ccff_head,
  output logic              shift_en,
  input  logic              ccff_tail,
  output logic [WORD_W-1:0] rb_data,
  output logic              rb_valid,
  output logic              busy,
  output logic              done
);

  localparam int IDX_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT_WORD,
    S_SHIFT,
    S_DONE
  } state_t;

  state_t            r_state;
  logic [WORD_W-1:0] r_sreg;
  logic [WORD_W-1:0] r_rb;
  logic [IDX_W-1:0]  r_bit_idx;
  logic [CNT_W-1:0]  r_total;

  logic              w_last_chain_bit;
  logic              w_last_bit;
  logic [WORD_W-1:0] w_sreg_shr;
  logic [WORD_W-1:0] w_rb_cap;

  // A word ends either at its own MSB or when the chain runs out of DFFs,
  // which truncates the final word of a load.
  assign w_last_chain_bit = (r_total == CNT_W'(CHAIN_LEN - 1));
  assign w_last_bit       = (r_bit_idx == IDX_W'(WORD_W - 1)) || w_last_chain_bit;
  assign w_sreg_shr       = r_sreg >> 1;

  // Readback word including the tail bit captured on this edge, so the word
  // can be presented the cycle after its last bit.
  always_comb begin
    w_rb_cap            = r_rb;
    w_rb_cap[r_bit_idx] = ccff_tail;
  end

  always_ff @(posedge prog_clk) begin
    if (prog_reset) begin
      r_state   <= S_IDLE;
      r_sreg    <= '0;
      r_rb      <= '0;
      r_bit_idx <= '0;
      r_total   <= '0;
      cfg_ready <= 1'b0;
      ccff_head <= 1'b0;
      shift_en  <= 1'b0;
      rb_data   <= '0;
      rb_valid  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      rb_valid <= 1'b0;
      case (r_state)
        S_IDLE, S_DONE: begin
          if (start) begin
            r_state   <= S_WAIT_WORD;
            r_total   <= '0;
            done      <= 1'b0;
            busy      <= 1'b1;
            cfg_ready <= 1'b1;
          end
        end

        S_WAIT_WORD: begin
          if (cfg_valid && cfg_ready) begin
            r_sreg    <= cfg_data;
            r_bit_idx <= '0;
            r_rb      <= '0;
            ccff_head <= cfg_data[0];
            shift_en  <= 1'b1;
            cfg_ready <= 1'b0;
            r_state   <= S_SHIFT;
          end
        end

        S_SHIFT: begin
          // ccff_head is registered, so it is loaded with the bit that the
          // chain will take on the next edge.
          r_sreg    <= w_sreg_shr;
          ccff_head <= w_sreg_shr[0];
          r_rb      <= w_rb_cap;
          r_bit_idx <= r_bit_idx + IDX_W'(1);
          r_total   <= r_total + CNT_W'(1);
          if (w_last_bit) begin
            rb_valid  <= 1'b1;
            rb_data   <= w_rb_cap;
            shift_en  <= 1'b0;
            ccff_head <= 1'b0;
            if (w_last_chain_bit) begin
              r_state <= S_DONE;
              done    <= 1'b1;
              busy    <= 1'b0;
            end else begin
              r_state   <= S_WAIT_WORD;
              cfg_ready <= 1'b1;
            end
          end
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ccff_chain_loader.sv
// tb/tb_ccff_chain_loader.sv - scoreboard bench for ccff_chain_loader with a DFF chain model
module tb_ccff_chain_loader;

  localparam int WORD_W    = 4;
  localparam int CHAIN_LEN = 10;
  localparam int NWORDS    = (CHAIN_LEN + WORD_W - 1) / WORD_W;

  logic                 prog_clk = 1'b0;
  logic                 prog_reset;
  logic                 start;
  logic [WORD_W-1:0]    cfg_data;
  logic                 cfg_valid;
  logic                 cfg_ready;
  logic                 ccff_head;
  logic                 shift_en;
  logic                 ccff_tail;
  logic [WORD_W-1:0]    rb_data;
  logic                 rb_valid;
  logic                 busy;
  logic                 done;

  always #5 prog_clk = ~prog_clk;

  ccff_chain_loader #(
    .WORD_W   (WORD_W),
    .CHAIN_LEN(CHAIN_LEN)
  ) dut (
    .prog_clk  (prog_clk),
    .prog_reset(prog_reset),
    .start     (start),
    .cfg_data  (cfg_data),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .ccff_head (ccff_head),
    .shift_en  (shift_en),
    .ccff_tail (ccff_tail),
    .rb_data   (rb_data),
    .rb_valid  (rb_valid),
    .busy      (busy),
    .done      (done)
  );

  // Chain of DFFs: index 0 is at the head, CHAIN_LEN-1 at the tail.
  logic [CHAIN_LEN-1:0] chain;
  logic [CHAIN_LEN-1:0] chain_init_val;
  logic                 load_req;

  always @(posedge prog_clk) begin
    if (load_req)      chain <= chain_init_val;
    else if (shift_en) chain <= {chain[CHAIN_LEN-2:0], ccff_head};
  end
  assign ccff_tail = chain[CHAIN_LEN-1];

  logic [WORD_W-1:0]    exp_q[$];
  logic [CHAIN_LEN-1:0] prev_stream;
  logic [WORD_W-1:0]    mon_e;
  int                   tests = 0;
  int                   fails = 0;
  int                   sh_cnt = 0;
  logic                 acc_edge = 1'b0;
  logic                 prev_rb = 1'b0;

  always @(posedge prog_clk) acc_edge <= cfg_valid && cfg_ready;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic timeout_fail(input string name);
    tests++;
    fails++;
    $display("FAIL %s: timed out, got no event expected one at %0t", name, $time);
  endtask

  // Stream order of a chain image: stream bit j is the j-th bit to leave the tail.
  function automatic logic [CHAIN_LEN-1:0] stream_of(input logic [CHAIN_LEN-1:0] img);
    logic [CHAIN_LEN-1:0] s;
    for (int j = 0; j < CHAIN_LEN; j++) s[j] = img[CHAIN_LEN-1-j];
    return s;
  endfunction

  // Monitor: shift counting, latency/hold rules and readback scoreboard.
  initial begin
    forever begin
      @(negedge prog_clk);
      if (prog_reset) sh_cnt = 0;
      else begin
        if (start && !busy) sh_cnt = 0;
        if (shift_en) sh_cnt++;
      end
      if (acc_edge) chk("first_shift_latency", shift_en, 1);
      if (cfg_ready) chk("no_shift_while_ready", shift_en, 0);
      if (rb_valid) begin
        chk("rb_single_pulse", prev_rb, 0);
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL rb_unexpected: got rb_data %0h expected no readback", rb_data);
        end else begin
          mon_e = exp_q.pop_front();
          chk("rb_data", rb_data, mon_e);
        end
      end
      prev_rb = rb_valid;
    end
  end

  task automatic pulse_start();
    @(posedge prog_clk); #1 start = 1'b1;
    @(posedge prog_clk); #1 start = 1'b0;
  endtask

  task automatic wait_ready(output bit ok);
    ok = 1'b0;
    for (int t = 0; t < 64; t++) begin
      @(negedge prog_clk);
      if (cfg_ready) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic do_load(input int gap, input bit poke);
    logic [CHAIN_LEN-1:0] stream;
    logic [CHAIN_LEN-1:0] snap;
    logic [CHAIN_LEN-1:0] exp_chain;
    logic [WORD_W-1:0]    w;
    logic [WORD_W-1:0]    e;
    bit                   ok;
    stream = '0;
    pulse_start();
    @(negedge prog_clk);
    chk("start_busy_done_ready", {busy, done, cfg_ready}, 3'b101);
    for (int wi = 0; wi < NWORDS; wi++) begin
      wait_ready(ok);
      if (!ok) begin
        timeout_fail("cfg_ready");
        return;
      end
      if (gap > 0 && wi == 1) begin
        snap = chain;
        repeat (gap) begin
          @(negedge prog_clk);
          chk("gap_ready_noshift", {cfg_ready, shift_en}, 2'b10);
        end
        chk("gap_chain_held", chain, snap);
      end else begin
        repeat ($urandom_range(0, 2)) @(negedge prog_clk);
      end
      w = WORD_W'($urandom);
      e = '0;
      for (int i = 0; i < WORD_W; i++) begin
        if (wi * WORD_W + i < CHAIN_LEN) begin
          e[i]                   = prev_stream[wi*WORD_W+i];
          stream[wi*WORD_W+i]    = w[i];
        end
      end
      exp_q.push_back(e);
      #1 cfg_data = w; cfg_valid = 1'b1;
      @(posedge prog_clk); #1 cfg_valid = 1'b0; cfg_data = WORD_W'($urandom);
      if (poke && wi == 1) begin
        start = 1'b1;
        @(posedge prog_clk); #1 start = 1'b0;
      end
    end
    for (int t = 0; t < 64; t++) begin
      @(negedge prog_clk);
      if (done) break;
    end
    chk("done_busy", {done, busy}, 2'b10);
    chk("shift_count", sh_cnt, CHAIN_LEN);
    for (int j = 0; j < CHAIN_LEN; j++) exp_chain[CHAIN_LEN-1-j] = stream[j];
    chk("chain_contents", chain, exp_chain);
    prev_stream = stream;
  endtask

  task automatic reset_test();
    bit ok;
    pulse_start();
    wait_ready(ok);
    if (!ok) begin
      timeout_fail("cfg_ready_rst");
      return;
    end
    #1 cfg_data = WORD_W'($urandom); cfg_valid = 1'b1;
    @(posedge prog_clk); #1 cfg_valid = 1'b0;
    for (int t = 0; t < 16; t++) begin
      @(negedge prog_clk); #1;
      if (sh_cnt >= 2) break;
    end
    prog_reset = 1'b1;
    @(posedge prog_clk); #1 prog_reset = 1'b0;
    chain_init_val = CHAIN_LEN'($urandom);
    load_req = 1'b1;
    @(negedge prog_clk);
    chk("reset_mid_load_outputs",
        {cfg_ready, ccff_head, shift_en, rb_valid, busy, done, rb_data}, 0);
    @(posedge prog_clk); #1 load_req = 1'b0;
    prev_stream = stream_of(chain_init_val);
    @(negedge prog_clk);
    chk("idle_after_reset", {busy, done, cfg_ready, shift_en}, 0);
  endtask

  initial begin
    prog_reset     = 1'b1;
    start          = 1'b0;
    cfg_valid      = 1'b0;
    cfg_data       = '0;
    load_req       = 1'b1;
    chain_init_val = CHAIN_LEN'($urandom);
    repeat (3) @(posedge prog_clk);
    #1 prog_reset = 1'b0; load_req = 1'b0;
    prev_stream = stream_of(chain_init_val);
    @(negedge prog_clk);
    chk("reset_state",
        {cfg_ready, ccff_head, shift_en, rb_valid, busy, done, rb_data}, 0);

    do_load(0, 1'b0);
    do_load(5, 1'b0);
    do_load(0, 1'b1);
    reset_test();
    for (int i = 0; i < 5; i++) do_load((i == 2) ? 6 : 0, (i == 3));

    repeat (4) @(negedge prog_clk);
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
